// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. It forwards operands from MEM/WB and stalls decode on load-use hazards.
// IDEX_FORWARD_EN enables forwarding. Without it, operands come straight from the latches and decode stalls on any RAW hazard.
module id_ex_stage #(
    parameter int DW  = 32,
    parameter int CW  = 5,
    parameter int SCW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           id_valid,
    input  logic [4:0]     id_rs_addr,
    input  logic [4:0]     id_rt_addr,
    input  logic [DW-1:0]  id_rs_data,
    input  logic [DW-1:0]  id_rt_data,
    input  logic [DW-1:0]  id_imm,
    input  logic           id_alu_src,
    input  logic [CW-1:0]  id_alu_ctrl,
    input  logic [4:0]     id_rd_addr,
    input  logic           id_reg_write,
    input  logic           id_mem_read,
    input  logic           mem_reg_write,
    input  logic [4:0]     mem_rd_addr,
    input  logic [DW-1:0]  mem_result,
    input  logic           wb_reg_write,
    input  logic [4:0]     wb_rd_addr,
    input  logic [DW-1:0]  wb_result,
    output logic           stall,
    output logic           ex_valid,
    output logic [DW-1:0]  ex_in1,
    output logic [DW-1:0]  ex_in2,
    output logic [CW-1:0]  ex_ctrl,
    output logic [DW-1:0]  ex_store_data,
    output logic [4:0]     ex_rd_addr,
    output logic           ex_reg_write,
    output logic           ex_mem_read,
    output logic [SCW-1:0] stall_cnt
);

    logic [4:0]     rs_addr_q, rt_addr_q, rd_q;
    logic [DW-1:0]  rs_data_q, rt_data_q, imm_q;
    logic           alu_src_q, reg_write_q, mem_read_q, valid_q;
    logic [CW-1:0]  ctrl_q;
    logic [SCW-1:0] cnt_q;
    logic [DW-1:0]  rs_fwd, rt_fwd;
    logic           hz;

    // Flush and stall both insert a bubble. The stalled ID instruction is re-presented by decode.
    always_ff @(posedge clk) begin
        if (rst || flush || stall) begin
            valid_q     <= 1'b0;
            rs_addr_q   <= 5'd0;
            rt_addr_q   <= 5'd0;
            rd_q        <= 5'd0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            ctrl_q      <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            valid_q     <= id_valid;
            rs_addr_q   <= id_rs_addr;
            rt_addr_q   <= id_rt_addr;
            rd_q        <= id_rd_addr;
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm;
            alu_src_q   <= id_alu_src;
            ctrl_q      <= id_alu_ctrl;
            reg_write_q <= id_reg_write;
            mem_read_q  <= id_mem_read;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stall && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef IDEX_FORWARD_EN
    // The MEM result is newer than the WB result, so MEM wins. $0 is never forwarded.
    always_comb begin
        rs_fwd = rs_data_q;
        rt_fwd = rt_data_q;
        if (rs_addr_q != 5'd0) begin
            if (mem_reg_write && mem_rd_addr == rs_addr_q)
                rs_fwd = mem_result;
            else if (wb_reg_write && wb_rd_addr == rs_addr_q)
                rs_fwd = wb_result;
        end
        if (rt_addr_q != 5'd0) begin
            if (mem_reg_write && mem_rd_addr == rt_addr_q)
                rt_fwd = mem_result;
            else if (wb_reg_write && wb_rd_addr == rt_addr_q)
                rt_fwd = wb_result;
        end
    end

    assign hz = valid_q && mem_read_q && (rd_q != 5'd0) && id_valid &&
                ((id_rs_addr == rd_q) || ((id_rt_addr == rd_q) && !id_alu_src));
`else
    logic rs_hit, rt_hit;
    logic unused_fwd;

    assign rs_fwd = rs_data_q;
    assign rt_fwd = rt_data_q;

    // Without forwarding, any producer still in flight blocks a dependent instruction.
    assign rs_hit = (id_rs_addr != 5'd0) &&
                    ((valid_q && reg_write_q && rd_q == id_rs_addr) ||
                     (mem_reg_write && mem_rd_addr == id_rs_addr) ||
                     (wb_reg_write && wb_rd_addr == id_rs_addr));
    assign rt_hit = (id_rt_addr != 5'd0) &&
                    ((valid_q && reg_write_q && rd_q == id_rt_addr) ||
                     (mem_reg_write && mem_rd_addr == id_rt_addr) ||
                     (wb_reg_write && wb_rd_addr == id_rt_addr));
    assign hz = id_valid && (rs_hit || (rt_hit && !id_alu_src));

    assign unused_fwd = ^{mem_result, wb_result, rs_addr_q, rt_addr_q};
`endif

    assign stall         = hz && !flush;
    assign ex_valid      = valid_q;
    assign ex_in1        = rs_fwd;
    assign ex_in2        = alu_src_q ? imm_q : rt_fwd;
    assign ex_store_data = rt_fwd;
    assign ex_ctrl       = ctrl_q;
    assign ex_rd_addr    = rd_q;
    assign ex_reg_write  = valid_q && reg_write_q;
    assign ex_mem_read   = valid_q && mem_read_q;
    assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage; expectations adapt to whether IDEX_FORWARD_EN is defined.
module tb_id_ex_stage;

`ifdef IDEX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [4:0] ADD = 5'b00010;
    localparam logic [4:0] SUB = 5'b00110;

    logic        clk = 1'b0;
    logic        rst, flush, id_valid, id_alu_src, id_reg_write, id_mem_read;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_alu_ctrl;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic [31:0] mem_result, wb_result;
    logic        stall, ex_valid, ex_reg_write, ex_mem_read;
    logic [31:0] ex_in1, ex_in2, ex_store_data;
    logic [4:0]  ex_ctrl, ex_rd_addr;
    logic [15:0] stall_cnt;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl), .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
        .stall(stall), .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2),
        .ex_ctrl(ex_ctrl), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        fl;
        logic [4:0]  rs, rt, ctrl, rd, mrd, wrd;
        logic [31:0] rsd, rtd, imm, mres, wres;
        logic        src, rw, mr, mrw, wrw;
        logic        e_stall, e_valid, e_rw, e_mr, dchk;
        logic [31:0] e_in1, e_in2, e_sd;
        logic [4:0]  e_ctrl, e_rd;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t vin(input logic fl, input logic [4:0] rs, input logic [31:0] rsd,
                                 input logic [4:0] rt, input logic [31:0] rtd, input logic src,
                                 input logic [31:0] imm, input logic [4:0] ctrl, input logic [4:0] rd,
                                 input logic rw, input logic mr,
                                 input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
                                 input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
        vec_t v;
        v.fl = fl; v.rs = rs; v.rsd = rsd; v.rt = rt; v.rtd = rtd; v.src = src; v.imm = imm;
        v.ctrl = ctrl; v.rd = rd; v.rw = rw; v.mr = mr;
        v.mrw = mrw; v.mrd = mrd; v.mres = mres; v.wrw = wrw; v.wrd = wrd; v.wres = wres;
        v.e_stall = 0; v.e_valid = 0; v.e_rw = 0; v.e_mr = 0; v.dchk = 0;
        v.e_in1 = 0; v.e_in2 = 0; v.e_sd = 0; v.e_ctrl = 0; v.e_rd = 0; v.e_cnt = 0;
        return v;
    endfunction

    function automatic vec_t vexp(input vec_t vi, input logic st, input logic [31:0] i1,
                                  input logic [31:0] i2, input logic [31:0] sd, input logic [4:0] c,
                                  input logic [4:0] rd, input logic rw, input logic mr,
                                  input logic [15:0] cnt);
        vec_t v = vi;
        v.e_stall = st; v.e_valid = 1; v.dchk = 1;
        v.e_in1 = i1; v.e_in2 = i2; v.e_sd = sd; v.e_ctrl = c; v.e_rd = rd;
        v.e_rw = rw; v.e_mr = mr; v.e_cnt = cnt;
        return v;
    endfunction

    function automatic vec_t vbub(input vec_t vi, input logic st, input logic [15:0] cnt);
        vec_t v = vi;
        v.e_stall = st; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s (step %0d): got %h, expected %h", nm, idx, act, exp);
    endtask

    task automatic drive(input vec_t v);
        flush = v.fl; id_valid = 1'b1;
        id_rs_addr = v.rs; id_rs_data = v.rsd; id_rt_addr = v.rt; id_rt_data = v.rtd;
        id_alu_src = v.src; id_imm = v.imm; id_alu_ctrl = v.ctrl; id_rd_addr = v.rd;
        id_reg_write = v.rw; id_mem_read = v.mr;
        mem_reg_write = v.mrw; mem_rd_addr = v.mrd; mem_result = v.mres;
        wb_reg_write = v.wrw; wb_rd_addr = v.wrd; wb_result = v.wres;
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk(idx, "stall", {31'b0, stall}, {31'b0, v.e_stall});
        @(posedge clk);
        #1;
        chk(idx, "ex_valid", {31'b0, ex_valid}, {31'b0, v.e_valid});
        chk(idx, "ex_ctrl", {27'b0, ex_ctrl}, {27'b0, v.e_ctrl});
        chk(idx, "ex_rd_addr", {27'b0, ex_rd_addr}, {27'b0, v.e_rd});
        chk(idx, "ex_reg_write", {31'b0, ex_reg_write}, {31'b0, v.e_rw});
        chk(idx, "ex_mem_read", {31'b0, ex_mem_read}, {31'b0, v.e_mr});
        chk(idx, "stall_cnt", {16'b0, stall_cnt}, {16'b0, v.e_cnt});
        if (v.dchk) begin
            chk(idx, "ex_in1", ex_in1, v.e_in1);
            chk(idx, "ex_in2", ex_in2, v.e_in2);
            chk(idx, "ex_store_data", ex_store_data, v.e_sd);
        end
    endtask

    initial begin
        vec_t z;
        vec_t lw;
        z = vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw = vin(0, 6, 100, 0, 0, 1, 8, ADD, 4, 1, 1, 0, 0, 0, 0, 0, 0);

        tbl[0]  = vexp(vin(0, 1, 3, 2, 1, 0, 0, ADD, 5, 1, 0, 0, 0, 0, 0, 0, 0),
                       0, 3, 1, 1, ADD, 5, 1, 0, 0);
        tbl[1]  = vin(0, 1, 3, 2, 1, 0, 0, ADD, 5, 1, 0, 1, 1, 7, 1, 1, 9);
        tbl[1]  = FWD ? vexp(tbl[1], 0, 7, 1, 1, ADD, 5, 1, 0, 0) : vbub(tbl[1], 1, 1);
        tbl[2]  = vexp(vin(0, 0, 3, 2, 1, 0, 0, ADD, 5, 1, 0, 1, 0, 7, 1, 0, 9),
                       0, 3, 1, 1, ADD, 5, 1, 0, FWD ? 16'd0 : 16'd1);
        tbl[3]  = vexp(lw, 0, 100, 8, 0, ADD, 4, 1, 1, FWD ? 16'd0 : 16'd1);
        tbl[4]  = vbub(vin(0, 4, 32'h11, 2, 1, 0, 0, ADD, 7, 1, 0, 0, 0, 0, 0, 0, 0),
                       1, FWD ? 16'd1 : 16'd2);
        tbl[5]  = vin(0, 4, 32'h11, 2, 1, 0, 0, ADD, 7, 1, 0, 1, 4, 32'h55, 0, 0, 0);
        tbl[5]  = FWD ? vexp(tbl[5], 0, 32'h55, 1, 1, ADD, 7, 1, 0, 1) : vbub(tbl[5], 1, 3);
        tbl[6]  = vin(0, 4, 32'h11, 2, 1, 0, 0, ADD, 7, 1, 0, 0, 0, 0, 1, 4, 32'h55);
        tbl[6]  = FWD ? vexp(tbl[6], 0, 32'h55, 1, 1, ADD, 7, 1, 0, 1) : vbub(tbl[6], 1, 4);
        tbl[7]  = vexp(vin(0, 4, 32'h55, 2, 1, 0, 0, ADD, 7, 1, 0, 0, 0, 0, 0, 0, 0),
                       0, 32'h55, 1, 1, ADD, 7, 1, 0, FWD ? 16'd1 : 16'd4);
        tbl[8]  = vexp(lw, 0, 100, 8, 0, ADD, 4, 1, 1, FWD ? 16'd1 : 16'd4);
        tbl[9]  = vbub(vin(1, 4, 32'h11, 2, 1, 0, 0, ADD, 7, 1, 0, 0, 0, 0, 0, 0, 0),
                       0, FWD ? 16'd1 : 16'd4);
        tbl[10] = vexp(vin(0, 1, 3, 3, 32'h33, 1, 32'hFFFF_FFFC, ADD, 8, 0, 0, FWD, 3, 32'hAB, 0, 0, 0),
                       0, 3, 32'hFFFF_FFFC, FWD ? 32'hAB : 32'h33, ADD, 8, 0, 0, FWD ? 16'd1 : 16'd4);
        tbl[11] = vin(0, 9, 32'h90, 3, 32'h33, 0, 0, SUB, 10, 1, 0, 1, 9, 32'h99, 1, 3, 32'hCD);
        tbl[11] = FWD ? vexp(tbl[11], 0, 32'h99, 32'hCD, 32'hCD, SUB, 10, 1, 0, 1) : vbub(tbl[11], 1, 5);
        tbl[12] = vexp(lw, 0, 100, 8, 0, ADD, 4, 1, 1, FWD ? 16'd1 : 16'd5);

        rst = 1'b1;
        drive(z);
        id_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk(-1, "rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk(-1, "rst_ex_ctrl", {27'b0, ex_ctrl}, 32'd0);
        chk(-1, "rst_ex_in1", ex_in1, 32'd0);
        chk(-1, "rst_stall", {31'b0, stall}, 32'd0);
        chk(-1, "rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) apply(i, tbl[i]);

        // Reset arriving while a load-use stall is asserted clears EX, so the stall drops.
        @(negedge clk);
        drive(vin(0, 4, 32'h11, 2, 1, 0, 0, ADD, 7, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk(100, "pre_rst_stall", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk(100, "post_rst_stall", {31'b0, stall}, 32'd0);
        chk(100, "post_rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk(100, "post_rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk(101, "after_rst_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        chk(101, "after_rst_ex_valid", {31'b0, ex_valid}, 32'd1);
        chk(101, "after_rst_in1", ex_in1, 32'h11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
